// File: rtl/lipsi_uart_loader.sv
// UART program loader for lipsi_processor: receives LEN/data/CHK frames and
// writes the data bytes into the 256-byte instruction memory.
//
// RX FSM
//   state   | meaning
//   R_IDLE  | line idle, waiting for a start-bit low level
//   R_START | half-bit wait, then confirm start bit (reject glitches)
//   R_DATA  | sample 8 data bits LSB first, one per bit period
//   R_STOP  | sample stop bit; 1 = byte_valid, 0 = frame_err
// Loader FSM
//   state   | meaning
//   L_IDLE  | waiting for a LEN byte
//   L_DATA  | writing data bytes, accumulating checksum
//   L_CHECK | waiting for the CHK byte
module lipsi_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err,
  output logic [7:0] byte_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_DATA, L_CHECK} ld_state_t;

  logic rx_meta_q, rx_sync_q;

  rx_state_t     rstate_q, rstate_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid, frame_err;

  ld_state_t     lstate_q, lstate_d;
  logic [8:0]    rem_q, rem_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    bcnt_q, bcnt_d;
  logic          hold_q, hold_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          wen_q, wen_d;
  logic [7:0]    waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate_q <= R_IDLE;
      rcnt_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      rcnt_q   <= rcnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    rstate_d   = rstate_q;
    rcnt_d     = rcnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (!rx_sync_q) begin
          rstate_d = R_START;
          rcnt_d   = '0;
          bit_d    = '0;
        end
      end
      R_START: begin
        if (rcnt_q == HALF_END) begin
          rcnt_d   = '0;
          rstate_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (rcnt_q == BIT_END) begin
          rcnt_d  = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) rstate_d = R_STOP;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (rcnt_q == BIT_END) begin
          rcnt_d     = '0;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
          rstate_d   = R_IDLE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lstate_q <= L_IDLE;
      rem_q    <= '0;
      addr_q   <= '0;
      sum_q    <= '0;
      bcnt_q   <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      tmr_q    <= '0;
    end else begin
      lstate_q <= lstate_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      sum_q    <= sum_d;
      bcnt_q   <= bcnt_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      done_q   <= done_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      tmr_q    <= tmr_d;
    end
  end

  // Inter-byte watchdog: reloaded by every byte, saturates at zero.
  assign timeout = (lstate_q != L_IDLE) && !byte_valid && (tmr_q == '0);

  always_comb begin
    lstate_d = lstate_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    sum_d    = sum_q;
    bcnt_d   = bcnt_q;
    hold_d   = hold_q;
    err_d    = err_q;
    done_d   = 1'b0;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    tmr_d    = tmr_q;

    if (lstate_q == L_IDLE || byte_valid) tmr_d = TMR_LOAD;
    else if (tmr_q != '0)                 tmr_d = tmr_q - 1'b1;

    case (lstate_q)
      L_IDLE: begin
        if (byte_valid) begin
          rem_d    = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
          addr_d   = '0;
          sum_d    = '0;
          bcnt_d   = '0;
          hold_d   = 1'b1;
          err_d    = 1'b0;
          lstate_d = L_DATA;
        end
      end
      L_DATA: begin
        if (frame_err || timeout) begin
          err_d    = 1'b1;
          lstate_d = L_IDLE;
        end else if (byte_valid) begin
          wen_d   = 1'b1;
          waddr_d = addr_q;
          wdata_d = shift_q;
          sum_d   = sum_q + shift_q;
          addr_d  = addr_q + 1'b1;
          bcnt_d  = bcnt_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == 9'd1) lstate_d = L_CHECK;
        end
      end
      L_CHECK: begin
        if (frame_err || timeout) begin
          err_d    = 1'b1;
          lstate_d = L_IDLE;
        end else if (byte_valid) begin
          if (shift_q == sum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          lstate_d = L_IDLE;
        end
      end
      default: lstate_d = L_IDLE;
    endcase
  end

  assign wr_en      = wen_q;
  assign wr_addr    = waddr_q;
  assign wr_data    = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign byte_count = bcnt_q;

endmodule

// File: tb/tb_lipsi_uart_loader.sv
// Directed bench for lipsi_uart_loader: sends UART frames and checks the
// memory writes, status flags and byte count against hand-computed values.
module tb_lipsi_uart_loader;

  localparam int CPB = 16;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       wr_en, cpu_hold, load_done, load_err;
  logic [7:0] wr_addr, wr_data, byte_count;

  lipsi_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int bstart = 0;
  int wr_n = 0;
  int done_n = 0;
  int wa [512];
  int wd [512];
  int wl [512];
  logic [7:0] fbuf [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        wa[wr_n] = int'(wr_addr);
        wd[wr_n] = int'(wr_data);
        wl[wr_n] = cyc - bstart;
        wr_n = wr_n + 1;
      end
      if (load_done) done_n = done_n + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    @(negedge clk);
    rx = 1'b0;
    bstart = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (good_stop) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (CPB - 4) @(negedge clk);
      rx = 1'b1;
      repeat (CPB + 4) @(negedge clk);
    end
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] len, input int n, input logic [7:0] chk);
    send_byte(len, 1'b1);
    for (int i = 0; i < n; i++) send_byte(fbuf[i], 1'b1);
    send_byte(chk, 1'b1);
  endtask

  int w0, d0, bad;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_cpu_hold", int'(cpu_hold), 0);
    check("rst_load_err", int'(load_err), 0);
    check("rst_byte_count", int'(byte_count), 0);
    reset = 1'b1;
    idle(20);

    // 1: basic 3-byte frame
    w0 = wr_n; d0 = done_n;
    send_byte(8'h03, 1'b1);
    check("t1_hold_after_len", int'(cpu_hold), 1);
    fbuf[0] = 8'hC7; fbuf[1] = 8'h0A; fbuf[2] = 8'hFF;
    for (int i = 0; i < 3; i++) send_byte(fbuf[i], 1'b1);
    check("t1_hold_in_check", int'(cpu_hold), 1);
    send_byte(8'hD0, 1'b1);
    check("t1_writes", wr_n - w0, 3);
    check("t1_latency", wl[w0], 155);
    check("t1_addr0", wa[w0], 0);   check("t1_data0", wd[w0], 'hC7);
    check("t1_addr1", wa[w0+1], 1); check("t1_data1", wd[w0+1], 'h0A);
    check("t1_addr2", wa[w0+2], 2); check("t1_data2", wd[w0+2], 'hFF);
    check("t1_done", done_n - d0, 1);
    check("t1_hold", int'(cpu_hold), 0);
    check("t1_err", int'(load_err), 0);
    check("t1_count", int'(byte_count), 3);

    // 2: bad checksum, then recovery
    w0 = wr_n; d0 = done_n;
    fbuf[0] = 8'h11; fbuf[1] = 8'h22;
    send_frame(8'h02, 2, 8'h34);
    check("t2_writes", wr_n - w0, 2);
    check("t2_err", int'(load_err), 1);
    check("t2_hold", int'(cpu_hold), 1);
    check("t2_no_done", done_n - d0, 0);
    send_byte(8'h01, 1'b1);
    check("t2_err_clr_at_len", int'(load_err), 0);
    send_byte(8'h05, 1'b1);
    send_byte(8'h05, 1'b1);
    check("t2_rec_done", done_n - d0, 1);
    check("t2_rec_hold", int'(cpu_hold), 0);
    check("t2_rec_addr", wa[wr_n-1], 0);

    // 3: LEN=0 means 256 bytes
    w0 = wr_n; d0 = done_n;
    for (int i = 0; i < 256; i++) fbuf[i] = 8'(i);
    send_frame(8'h00, 256, 8'h80);
    check("t3_writes", wr_n - w0, 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (wa[w0+i] != i || wd[w0+i] != i) bad++;
    check("t3_addr_data_errs", bad, 0);
    check("t3_done", done_n - d0, 1);
    check("t3_hold", int'(cpu_hold), 0);
    check("t3_err", int'(load_err), 0);
    check("t3_count", int'(byte_count), 0);

    // 4: glitch, then stop-bit error mid-frame
    w0 = wr_n; d0 = done_n;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(60);
    check("t4_glitch_hold", int'(cpu_hold), 0);
    check("t4_glitch_count", int'(byte_count), 0);
    check("t4_glitch_writes", wr_n - w0, 0);
    send_byte(8'h03, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(40);
    check("t4_ferr_err", int'(load_err), 1);
    check("t4_ferr_hold", int'(cpu_hold), 1);
    check("t4_ferr_writes", wr_n - w0, 1);
    fbuf[0] = 8'h5A;
    send_frame(8'h01, 1, 8'h5A);
    check("t4_rec_done", done_n - d0, 1);
    check("t4_rec_err", int'(load_err), 0);
    check("t4_rec_hold", int'(cpu_hold), 0);

    // 5: inter-byte timeout
    w0 = wr_n; d0 = done_n;
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(1900);
    check("t5_err_before_tmo", int'(load_err), 0);
    idle(200);
    check("t5_err_tmo", int'(load_err), 1);
    check("t5_hold_tmo", int'(cpu_hold), 1);
    check("t5_writes", wr_n - w0, 2);
    fbuf[0] = 8'h10; fbuf[1] = 8'h20;
    send_frame(8'h02, 2, 8'h30);
    check("t5_rec_done", done_n - d0, 1);
    check("t5_rec_hold", int'(cpu_hold), 0);
    check("t5_rec_addr", wa[wr_n-1], 1);

    // 6: reset in the middle of data byte 2
    send_byte(8'h05, 1'b1);
    send_byte(8'h12, 1'b1);
    check("t6_hold_pre", int'(cpu_hold), 1);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_hold", int'(cpu_hold), 0);
    check("t6_rst_count", int'(byte_count), 0);
    check("t6_rst_wr_en", int'(wr_en), 0);
    check("t6_rst_addr", int'(wr_addr), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(40);
    w0 = wr_n; d0 = done_n;
    fbuf[0] = 8'hA1; fbuf[1] = 8'hB2;
    send_frame(8'h02, 2, 8'h53);
    check("t6_writes", wr_n - w0, 2);
    check("t6_addr0", wa[w0], 0);   check("t6_data0", wd[w0], 'hA1);
    check("t6_addr1", wa[w0+1], 1); check("t6_data1", wd[w0+1], 'hB2);
    check("t6_done", done_n - d0, 1);
    check("t6_hold", int'(cpu_hold), 0);
    check("t6_count", int'(byte_count), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lipsi_uart_loader.md
Name: lipsi_uart_loader

Overview:
- Upstream stage of lipsi_processor: receives a program image over a UART line and writes it into the processor's 256-byte instruction memory through a write port.
- Holds the processor in reset while a load is in progress, and after a failed load.
- Replaces the hard-coded initial program; lets the board be reprogrammed without resynthesis.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
TIMEOUT_CLKS, 10000000, idle clk cycles allowed between bytes inside a frame before aborting.

Ports:
clk  input  1  system clock (100 MHz board clock).
reset  input  1  asynchronous, active-low reset (0 = reset).
rx  input  1  UART receive line, idle high, asynchronous to clk.
wr_en  output  1  instruction-memory write strobe, one cycle per data byte.
wr_addr  output  8  instruction-memory write address.
wr_data  output  8  instruction-memory write data.
cpu_hold  output  1  drives the processor reset; 1 = hold the processor.
load_done  output  1  one-cycle pulse when the frame is accepted.
load_err  output  1  sticky error flag.
byte_count  output  8  number of data bytes written in the current or last frame (wraps at 256).

Behaviour:
- Reset (reset=0, asynchronous) values:
  - All outputs 0.
  - Both FSMs idle.
  - rx synchroniser flops preset to 1.
- rx passes through a 2-FF synchroniser; the RX FSM uses only the synchronised value.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: sync rx = 0 -> R_START, bit counter cleared.
  - R_START: wait CLKS_PER_BIT/2 cycles, then resample.
    - 0 -> R_DATA.
    - 1 -> false start, return to R_IDLE with no event.
  - R_DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT cycles.
    - 1 -> internal byte_valid pulse for one cycle.
    - 0 -> internal frame_err pulse.
    - Either case -> R_IDLE.
- Frame format: LEN byte, then N data bytes, then CHK byte.
  - N = LEN, except LEN = 0 means N = 256.
  - CHK = sum of the data bytes mod 256. LEN is not included in the sum.
- Loader FSM states: L_IDLE, L_DATA, L_CHECK.
  - L_IDLE, on byte_valid:
    - Latch N; clear address, checksum accumulator and byte_count.
    - Set cpu_hold = 1; clear load_err.
    - Go to L_DATA.
  - L_DATA, on byte_valid: in the next cycle, wr_en = 1, wr_addr = address, wr_data = byte.
    - Checksum += byte; address += 1; byte_count += 1.
    - After the Nth byte -> L_CHECK.
  - L_CHECK, on byte_valid:
    - Byte == checksum: load_done pulses 1 cycle, cpu_hold -> 0 in that same cycle, -> L_IDLE.
    - Otherwise: load_err = 1, cpu_hold stays 1, -> L_IDLE.
- Aborts in L_DATA/L_CHECK:
  - frame_err, or TIMEOUT_CLKS cycles with no byte_valid.
  - Action: load_err = 1, cpu_hold stays 1, return to L_IDLE.
  - Memory bytes already written are not rolled back.
- Write and address rules:
  - Latency from stop-bit sample to wr_en is exactly 1 cycle.
  - wr_en is never asserted in L_IDLE or L_CHECK.
  - The 8-bit address wraps 255 -> 0 only after the 256th byte, which is the end of the data phase.
- Failure recovery: cpu_hold remains 1 after any failure until a later frame succeeds. A new LEN byte received in L_IDLE always starts a new frame.
- Reset mid-frame: everything returns to reset values, including cpu_hold = 0, so the processor runs whatever the memory holds.
- Timeout counter:
  - Only runs in L_DATA/L_CHECK.
  - Restarts on every byte_valid.
  - Saturates, never wraps.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_CLKS=2000):
1. Send frame 03, C7, 0A, FF, CHK=D0 -> wr_en pulses at addresses 0,1,2 with data C7,0A,FF; load_done pulses once; cpu_hold 1 -> 0; load_err=0; byte_count=3.
2. Send frame 02, 11, 22, CHK=34 (correct is 33) -> two writes occur; load_err=1; cpu_hold stays 1; no load_done. Then a correct frame 01, 05, 05 -> load_err clears at its LEN byte; load_done pulses; cpu_hold=0.
3. LEN=00 followed by 256 bytes of value k (k = 0..255), CHK=80 -> 256 writes at addresses 0..255, no early wrap; load_done pulses; byte_count=0.
4. Glitch: rx low for 4 cycles in idle -> false start, no byte_valid, no state change. Then a byte with stop bit forced 0 during L_DATA -> load_err=1, FSM back to L_IDLE.
5. Send LEN=04 and 2 data bytes, then rx idle for 2100 cycles -> load_err=1 at the timeout; cpu_hold=1; a following valid frame succeeds.
6. Assert reset=0 during data byte 2 of a 5-byte frame -> all outputs 0 immediately; after release, a full valid frame loads correctly starting at address 0.
